// File: rtl/hamming_frame_encoder.sv
// -----------------------------------------------------------------------------
// hamming_frame_encoder
//
// Serial Hamming(7,4) frame encoder.
//   - Collects DATA_BITS = 4*N_NIBBLES serial bits. The first accepted bit is
//     the data word MSB.
//   - Encodes each nibble into a 7-bit codeword {d3,d2,d1,d0,p2,p1,p0}.
//   - Prepends a sync header: SYNC_FIRST for the first frame after reset,
//     SYNC_WORD for every later frame.
//   - Shifts the frame out MSB-first.
//   - Double-buffered: the next word fills while the current frame shifts.
//
// Optional feature (macro HAMMING_SECDED_EN):
//   When defined, each codeword gains an even overall parity bit p3 and becomes
//   {c_j, p3}. The frame is then SYNC_BITS + 8*N_NIBBLES bits long.
//
// Handshakes:
//   Both ports follow valid/ready rules. A transfer happens on a rising edge
//   where valid && ready. A source never retracts valid-qualified data before
//   that transfer. While out_valid=1 && out_ready=0, out_bit, out_sof and
//   out_eof hold steady.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_bit       serial data bit
//   in_valid     in_bit is valid
//   in_ready     block can accept a bit (input buffer not full)
//   out_bit      serial frame bit (shifter MSB)
//   out_valid    out_bit is valid
//   out_ready    downstream accepts out_bit
//   out_sof      out_bit is the first header bit
//   out_eof      out_bit is the last frame bit
//   frame_count  frames fully transmitted (wraps)
//   dbg_state_o  output shifter state (0 = idle, 1 = sending)
// -----------------------------------------------------------------------------
module hamming_frame_encoder #(
  parameter int                   N_NIBBLES  = 8,
  parameter int                   SYNC_BITS  = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_FIRST = 8'h6E,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD  = 8'h7E,
  parameter int                   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] frame_count,
  output logic             dbg_state_o
);

  localparam int DATA_BITS = 4 * N_NIBBLES;
`ifdef HAMMING_SECDED_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif
  localparam int FRAME_BITS = SYNC_BITS + CW * N_NIBBLES;
  localparam int FILL_W     = $clog2(DATA_BITS);
  localparam int BCNT_W     = $clog2(FRAME_BITS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Input side state
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [FILL_W-1:0]     fill_cnt_q;
  logic [FILL_W-1:0]     wr_idx;
  logic                  buf_full_q;
  logic                  first_q;

  // Output side state
  state_e                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] frame_d;
  logic [BCNT_W-1:0]     bit_cnt_q;
  logic                  sof_q;
  logic                  eof_q;
  logic [CNT_W-1:0]      frame_cnt_q;

  // Handshake and transfer qualifiers
  logic accept;
  logic last_fill;
  logic out_fire;
  logic last_bit_fire;
  logic load;

  // Encoder scratch
  logic [3:0]    nib;
  logic [6:0]    cw7;

  assign in_ready  = !buf_full_q;
  assign accept    = in_valid && in_ready;
  assign last_fill = (fill_cnt_q == FILL_W'(DATA_BITS - 1));
  // Bit k of the word lands at data[DATA_BITS-1-k].
  assign wr_idx    = FILL_W'(DATA_BITS - 1) - fill_cnt_q;

  assign out_valid     = (state_q == ST_SEND);
  assign out_fire      = out_valid && out_ready;
  assign last_bit_fire = out_fire && eof_q;
  // A full buffer moves into the shifter when the shifter is idle, or on the
  // very edge that accepts its last bit. The second case gives gap-free
  // back-to-back frames.
  assign load          = buf_full_q && ((state_q == ST_IDLE) || last_bit_fire);

  assign out_bit     = shift_q[FRAME_BITS-1];
  assign out_sof     = sof_q;
  assign out_eof     = eof_q;
  assign frame_count = frame_cnt_q;
  assign dbg_state_o = state_q;

  always_comb begin
    data_d = data_q;
    if (accept) begin
      data_d[wr_idx] = in_bit;
    end
  end

  // Frame image built from the buffered word.
  // Codeword j occupies frame_d[CW*j +: CW]; the header sits on top.
  always_comb begin
    frame_d = '0;
    nib     = '0;
    cw7     = '0;
    frame_d[FRAME_BITS-1 -: SYNC_BITS] = first_q ? SYNC_FIRST : SYNC_WORD;
    for (int j = 0; j < N_NIBBLES; j++) begin
      nib = data_q[4*j +: 4];
      cw7 = {nib,
             nib[1] ^ nib[2] ^ nib[3],
             nib[0] ^ nib[2] ^ nib[3],
             nib[0] ^ nib[1] ^ nib[3]};
`ifdef HAMMING_SECDED_EN
      frame_d[CW*j +: CW] = {cw7, ^cw7};
`else
      frame_d[CW*j +: CW] = cw7;
`endif
    end
  end

  // Input fill and buffer ownership.
  // accept and load are mutually exclusive: accept needs !buf_full_q and
  // load needs buf_full_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      fill_cnt_q <= '0;
      buf_full_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      data_q <= data_d;
      if (accept) begin
        if (last_fill) begin
          fill_cnt_q <= '0;
          buf_full_q <= 1'b1;
        end else begin
          fill_cnt_q <= fill_cnt_q + FILL_W'(1);
        end
      end else if (load) begin
        buf_full_q <= 1'b0;
      end
      if (load) begin
        first_q <= 1'b0;
      end
    end
  end

  // Output shifter FSM with registered sof/eof flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (last_bit_fire) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (load) begin
        state_q   <= ST_SEND;
        shift_q   <= frame_d;
        bit_cnt_q <= '0;
        sof_q     <= 1'b1;
        eof_q     <= 1'b0;
      end else if (out_fire) begin
        if (eof_q) begin
          state_q   <= ST_IDLE;
          shift_q   <= '0;
          bit_cnt_q <= '0;
          sof_q     <= 1'b0;
          eof_q     <= 1'b0;
        end else begin
          state_q   <= ST_SEND;
          shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
          sof_q     <= 1'b0;
          // The next bit shown is the last one when this bit is second-to-last.
          eof_q     <= (bit_cnt_q == BCNT_W'(FRAME_BITS - 2));
        end
      end
    end
  end

endmodule
